// File: rtl/ysyx_22050854_div_unit_if.sv
// ysyx_22050854_div_unit_if: EXU <-> divider request/result handshake bundle.
interface ysyx_22050854_div_unit_if #(parameter int XLEN = 64);
    logic            div_valid;
    logic            div_ready;
    logic            div_signed;
    logic            div_word;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    modport master (
        output div_valid, div_signed, div_word, dividend, divisor, flush, out_ready,
        input  div_ready, out_valid, quotient, remainder
    );
    modport slave (
        input  div_valid, div_signed, div_word, dividend, divisor, flush, out_ready,
        output div_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/ysyx_22050854_div_unit.sv
// ysyx_22050854_div_unit: iterative restoring RV64M divider (DIV/DIVU/REM/REMU and W forms).
module ysyx_22050854_div_unit #(parameter int XLEN = 64) (
    input logic                  clk,
    input logic                  rst_n,
    ysyx_22050854_div_unit_if.slave io
);
    localparam int W  = XLEN / 2;
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [XLEN-1:0] MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [W-1:0]    MIN_W = {1'b1, {(W-1){1'b0}}};
    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN:0]   r_q, r_d;
    logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, word_q, word_d;
    logic [XLEN-1:0] src_a, src_b, abs_a, abs_b, sq, sr, qv, rv;
    logic [XLEN+1:0] diff;
    logic [CW-1:0]   n_iter;
    logic            sa, sb, div_zero, ovf, accept;
    always_comb begin
        src_a    = io.div_word ? {{W{io.div_signed & io.dividend[W-1]}}, io.dividend[W-1:0]} : io.dividend;
        src_b    = io.div_word ? {{W{io.div_signed & io.divisor[W-1]}}, io.divisor[W-1:0]} : io.divisor;
        sa       = io.div_signed & src_a[XLEN-1];
        sb       = io.div_signed & src_b[XLEN-1];
        abs_a    = sa ? -src_a : src_a;
        abs_b    = sb ? -src_b : src_b;
        div_zero = src_b == '0;
        ovf      = io.div_signed & (&src_b) & (io.div_word ? src_a[W-1:0] == MIN_W : src_a == MIN);
        // Special cases are loaded as final results with no fix-up flags, so DONE shows them directly.
        sq       = div_zero ? '1 : src_a;
        sr       = div_zero ? (io.div_word ? {{W{io.dividend[W-1]}}, io.dividend[W-1:0]} : io.dividend) : '0;
        diff     = {r_q, a_q[XLEN-1]} - {2'b0, b_q};
        n_iter   = word_q ? CW'(W) : CW'(XLEN);
        qv       = q_neg_q ? -a_q : a_q;
        rv       = r_neg_q ? -r_q[XLEN-1:0] : r_q[XLEN-1:0];
        accept   = io.div_valid & (state_q == IDLE) & !io.flush;
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        word_d   = word_q;
        if (accept && (div_zero || ovf)) begin
            state_d = DONE;
            a_d     = sq;
            r_d     = {1'b0, sr};
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            word_d  = 1'b0;
        end else if (accept) begin
            state_d = BUSY;
            cnt_d   = '0;
            // W operands are left-aligned so the MSB-first shift sees them after 32 steps.
            a_d     = io.div_word ? {abs_a[W-1:0], {W{1'b0}}} : abs_a;
            b_d     = abs_b;
            r_d     = '0;
            q_neg_d = sa ^ sb;
            r_neg_d = sa;
            word_d  = io.div_word;
        end else if (state_q == BUSY) begin
            a_d     = {a_q[XLEN-2:0], !diff[XLEN+1]};
            r_d     = diff[XLEN+1] ? {r_q[XLEN-1:0], a_q[XLEN-1]} : diff[XLEN:0];
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_d == n_iter) ? DONE : BUSY;
        end else if (state_q == DONE && io.out_ready) begin
            state_d = IDLE;
        end
        if (io.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            word_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            word_q  <= word_d;
        end
    end
    assign io.div_ready = state_q == IDLE;
    assign io.out_valid = state_q == DONE;
    assign io.quotient  = word_q ? {{W{qv[W-1]}}, qv[W-1:0]} : qv;
    assign io.remainder = word_q ? {{W{rv[W-1]}}, rv[W-1:0]} : rv;
endmodule

// File: tb/tb_ysyx_22050854_div_unit.sv
// tb_ysyx_22050854_div_unit: directed checks of the iterative divider.
`timescale 1ns/1ps
module tb_ysyx_22050854_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    ysyx_22050854_div_unit_if #(.XLEN(64)) bus();
    ysyx_22050854_div_unit #(.XLEN(64)) dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));
    always #5 clk = ~clk;

    task automatic run(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b, output int cyc);
        @(negedge clk);
        bus.div_signed = s;
        bus.div_word   = w;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_valid  = 1'b1;
        @(posedge clk);
        #1 bus.div_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.div_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.div_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.quotient !== 64'h0) begin failures++; $display("FAIL reset_q got=%h exp=0", bus.quotient); end
        checks++; if (bus.remainder !== 64'h0) begin failures++; $display("FAIL reset_r got=%h exp=0", bus.remainder); end
    endtask

    task automatic test_signed64();
        int cyc;
        run(1'b1, 1'b0, -64'sd7, 64'd2, cyc);
        checks++; if (cyc !== 65) begin failures++; $display("FAIL s64_latency got=%0d exp=65", cyc); end
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL s64_q got=%h exp=fffffffffffffffd", bus.quotient); end
        checks++; if (bus.remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL s64_r got=%h exp=ffffffffffffffff", bus.remainder); end
        drain();
        run(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, cyc);
        checks++; if (bus.quotient !== 64'h1999_9999_9999_9999) begin failures++; $display("FAIL u64_q got=%h exp=1999999999999999", bus.quotient); end
        checks++; if (bus.remainder !== 64'd5) begin failures++; $display("FAIL u64_r got=%h exp=5", bus.remainder); end
        drain();
    endtask

    task automatic test_div_zero();
        int cyc;
        run(1'b0, 1'b0, 64'h1234, 64'h0, cyc);
        checks++; if (cyc !== 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", cyc); end
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL dz_q got=%h exp=ffffffffffffffff", bus.quotient); end
        checks++; if (bus.remainder !== 64'h1234) begin failures++; $display("FAIL dz_r got=%h exp=1234", bus.remainder); end
        drain();
        run(1'b0, 1'b1, 64'h5_8000_0001, 64'h7_0000_0000, cyc);
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL dzw_q got=%h exp=ffffffffffffffff", bus.quotient); end
        checks++; if (bus.remainder !== 64'hFFFF_FFFF_8000_0001) begin failures++; $display("FAIL dzw_r got=%h exp=ffffffff80000001", bus.remainder); end
        drain();
    endtask

    task automatic test_overflow();
        int cyc;
        run(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, cyc);
        checks++; if (cyc !== 1) begin failures++; $display("FAIL ovf_latency got=%0d exp=1", cyc); end
        checks++; if (bus.quotient !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL ovf_q got=%h exp=8000000000000000", bus.quotient); end
        checks++; if (bus.remainder !== 64'h0) begin failures++; $display("FAIL ovf_r got=%h exp=0", bus.remainder); end
        drain();
        run(1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, cyc);
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL ovfw_q got=%h exp=ffffffff80000000", bus.quotient); end
        checks++; if (bus.remainder !== 64'h0) begin failures++; $display("FAIL ovfw_r got=%h exp=0", bus.remainder); end
        drain();
    endtask

    task automatic test_word();
        int cyc;
        run(1'b0, 1'b1, 64'h1_8000_0000, 64'h1, cyc);
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL divuw_q got=%h exp=ffffffff80000000", bus.quotient); end
        checks++; if (bus.remainder !== 64'h0) begin failures++; $display("FAIL divuw_r got=%h exp=0", bus.remainder); end
        drain();
        run(1'b1, 1'b1, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, cyc);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL remw_latency got=%0d exp=33", cyc); end
        checks++; if (bus.remainder !== 64'h1) begin failures++; $display("FAIL remw_r got=%h exp=1", bus.remainder); end
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL remw_q got=%h exp=fffffffffffffffd", bus.quotient); end
        drain();
    endtask

    task automatic test_backpressure();
        int cyc;
        run(1'b0, 1'b0, 64'd100, 64'd7, cyc);
        bus.dividend   = 64'd50;
        bus.divisor    = 64'd5;
        bus.div_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, bus.out_valid); end
            checks++; if (bus.div_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, bus.div_ready); end
            checks++; if (bus.quotient !== 64'd14 || bus.remainder !== 64'd2) begin failures++; $display("FAIL bp_hold[%0d] got=%h/%h exp=e/2", i, bus.quotient, bus.remainder); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.div_ready !== 1'b1) begin failures++; $display("FAIL bp_handshake got=v%b r%b exp=v0 r1", bus.out_valid, bus.div_ready); end
        @(posedge clk);
        #1 bus.div_valid = 1'b0;
        checks++; if (bus.div_ready !== 1'b0) begin failures++; $display("FAIL bp_accept got=%b exp=0", bus.div_ready); end
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        checks++; if (cyc !== 65) begin failures++; $display("FAIL bp2_latency got=%0d exp=65", cyc); end
        checks++; if (bus.quotient !== 64'd10 || bus.remainder !== 64'd0) begin failures++; $display("FAIL bp2_result got=%h/%h exp=a/0", bus.quotient, bus.remainder); end
        drain();
    endtask

    task automatic test_abort();
        int  cyc;
        logic seen;
        @(negedge clk);
        bus.div_signed = 1'b0;
        bus.div_word   = 1'b0;
        bus.dividend   = 64'd1000;
        bus.divisor    = 64'd3;
        bus.div_valid  = 1'b1;
        @(posedge clk);
        #1 bus.div_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        checks++; if (bus.div_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_idle got=r%b v%b exp=r1 v0", bus.div_ready, bus.out_valid); end
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_result got=%b exp=0", seen); end
        @(negedge clk);
        bus.dividend  = 64'hFFFF;
        bus.div_valid = 1'b1;
        @(posedge clk);
        #1 bus.div_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.div_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_hs got=r%b v%b exp=r1 v0", bus.div_ready, bus.out_valid); end
        checks++; if (bus.quotient !== 64'h0 || bus.remainder !== 64'h0) begin failures++; $display("FAIL rst_mid_data got=%h/%h exp=0/0", bus.quotient, bus.remainder); end
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 1'b0, 64'd100, 64'd7, cyc);
        checks++; if (cyc !== 65) begin failures++; $display("FAIL fresh_latency got=%0d exp=65", cyc); end
        checks++; if (bus.quotient !== 64'd14 || bus.remainder !== 64'd2) begin failures++; $display("FAIL fresh_result got=%h/%h exp=e/2", bus.quotient, bus.remainder); end
        drain();
    endtask

    initial begin
        bus.div_valid  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_word   = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_signed64();
        test_div_zero();
        test_overflow();
        test_word();
        test_backpressure();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
